bcd_scan_display: RTL and testbench

- Parametrised N-digit BCD counter with built-in time-multiplexed seven-segment scan driver.
- Replaces separate divided-clock counters and static anode tie-offs: one clock domain; prescaler and scan rate generated as single-cycle enables.
- Supports up/down counting, parallel load, synchronous clear and leading-zero blanking.
- Sits between board-level clock/reset and the display pins.

---
 rtl/bcd_scan_display.sv | 164 ++++++++++++++++
 tb/tb_bcd_scan_display.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// N-digit BCD up/down counter with integrated time-multiplexed seven-segment
// scan driver. A single clock domain is used; the count prescaler and the
// scan rate are produced as single-cycle enables.
module bcd_scan_display #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000,
  parameter int SCAN_DIV   = 500,
  parameter int BLANK_LZ   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    wrap,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [TW-1:0]           pre_cnt;
  logic                    tick;
  logic [SW-1:0]           scan_cnt;
  logic [IW-1:0]           scan_idx;
  logic [4*NUM_DIGITS-1:0] value_nxt;
  logic [4*NUM_DIGITS-1:0] load_sat;
  logic                    wrap_nxt;
  logic [NUM_DIGITS-1:0]   blank;
  logic [3:0]              cur_digit;
  logic                    cur_blank;
  logic [6:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;

  // Clamp a non-BCD nibble to 9.
  function automatic logic [3:0] sat_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit; non-BCD is dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign tick = en && (pre_cnt == TW'(TICK_DIV - 1));

  // Ripple increment/decrement across digits; a carry out of the top digit is the wrap.
  always_comb begin
    logic       carry;
    logic [3:0] d;
    value_nxt = value;
    load_sat  = '0;
    carry     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = value[4*i +: 4];
      load_sat[4*i +: 4] = sat_digit(load_val[4*i +: 4]);
      if (carry) begin
        if (up) begin
          if (d == 4'd9) value_nxt[4*i +: 4] = 4'd0;
          else begin
            value_nxt[4*i +: 4] = d + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (d == 4'd0) value_nxt[4*i +: 4] = 4'd9;
          else begin
            value_nxt[4*i +: 4] = d - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    wrap_nxt = carry;
  end

  // Prescaler: runs only while enabled, restarts on clear or load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pre_cnt <= '0;
    else if (clr || load) pre_cnt <= '0;
    else if (en) pre_cnt <= tick ? '0 : pre_cnt + TW'(1);
  end

  // Count register with clr > load > tick priority; wrap pulses with the update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
      wrap  <= 1'b0;
    end else if (clr) begin
      value <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      value <= load_sat;
      wrap  <= 1'b0;
    end else if (tick) begin
      value <= value_nxt;
      wrap  <= wrap_nxt;
    end else begin
      wrap  <= 1'b0;
    end
  end

  // Free-running scan slot timer and digit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // Leading-zero mask, then pick the digit and drive pattern for the current slot.
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    blank     = '0;
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (value[4*i +: 4] == 4'd0);
      blank[i] = (BLANK_LZ != 0) && (i != 0) && zero_run;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == scan_idx) begin
        cur_digit = value[4*i +: 4];
        cur_blank = blank[i];
      end
    end
    seg_nxt = cur_blank ? 7'h7F : seg_decode(cur_digit);
    an_nxt  = cur_blank ? '1 : ~(NUM_DIGITS'(1) << scan_idx);
  end

  // Registered display outputs so the anodes change cleanly on a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= 7'b1000000;
      an  <= ~NUM_DIGITS'(1);
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with small dividers.
module tb_bcd_scan_display;

  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, up, load, clr;
  logic [15:0]   load_val;
  logic [15:0]   value;
  logic          wrap;
  logic [6:0]    seg;
  logic [ND-1:0] an;

  int n_checks = 0;
  int n_errors = 0;
  int edges;
  int wraps_seen;
  int idx;

  bcd_scan_display #(
    .NUM_DIGITS(ND),
    .TICK_DIV  (4),
    .SCAN_DIV  (2),
    .BLANK_LZ  (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up      (up),
    .load    (load),
    .load_val(load_val),
    .clr     (clr),
    .value   (value),
    .wrap    (wrap),
    .seg     (seg),
    .an      (an)
  );

  always #5 clk = ~clk;

  // Rising edges since the last reset release; gives the expected scan slot.
  always @(posedge clk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are sampled on the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    load_val = v;
    cyc();
    load = 1'b0;
  endtask

  function automatic logic [3:0] exp_an(input int i);
    case (i)
      0: return 4'b1110;
      1: return 4'b1101;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int i);
    case (i)
      0: return 7'b0100100;
      1: return 7'b0011001;
      default: return 7'h7F;
    endcase
  endfunction

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; clr = 1'b0; load_val = '0;
    repeat (2) @(negedge clk);
    check("rst_value", value, 16'h0000);
    check("rst_wrap",  wrap, 1'b0);
    check("rst_an",    an, 4'b1110);
    check("rst_seg",   seg, 7'b1000000);

    // Count up for 40 cycles: one step every 4 cycles.
    rst = 1'b1; en = 1'b1; up = 1'b1;
    wraps_seen = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (wrap) wraps_seen++;
      if (i == 3) check("up_before_tick", value, 16'h0000);
      if (i == 4) check("up_first_tick", value, 16'h0001);
    end
    check("up_40", value, 16'h0010);
    check("up_no_wrap", wraps_seen, 0);

    // Up wrap from 9998.
    do_load(16'h9998);
    check("load_9998", value, 16'h9998);
    repeat (3) cyc();
    check("hold_9998", value, 16'h9998);
    cyc();
    check("tick_9999", value, 16'h9999);
    check("tick_9999_wrap", wrap, 1'b0);
    repeat (3) cyc();
    check("pre_wrap_wrap", wrap, 1'b0);
    cyc();
    check("wrap_up_value", value, 16'h0000);
    check("wrap_up_pulse", wrap, 1'b1);
    cyc();
    check("wrap_up_end", wrap, 1'b0);

    // Down count through zero.
    up = 1'b0;
    do_load(16'h0001);
    repeat (4) cyc();
    check("down_0000", value, 16'h0000);
    check("down_0000_wrap", wrap, 1'b0);
    repeat (4) cyc();
    check("down_9999", value, 16'h9999);
    check("down_wrap_pulse", wrap, 1'b1);
    cyc();
    check("down_wrap_end", wrap, 1'b0);
    en = 1'b0;
    do_load(16'hA3F2);
    check("load_sat", value, 16'h9392);

    // Load collides with a tick: load wins and the prescaler restarts.
    en = 1'b1; up = 1'b1;
    do_load(16'h0123);
    repeat (3) cyc();
    do_load(16'h0500);
    check("load_over_tick", value, 16'h0500);
    repeat (3) cyc();
    check("restart_hold", value, 16'h0500);
    cyc();
    check("restart_tick", value, 16'h0501);

    // Clear and load at a tick edge: clear wins.
    repeat (3) cyc();
    clr = 1'b1; load = 1'b1; load_val = 16'h5555;
    cyc();
    clr = 1'b0; load = 1'b0;
    check("clr_load_value", value, 16'h0000);
    check("clr_load_wrap", wrap, 1'b0);
    do_load(16'h0777);
    cyc();
    en = 1'b0;
    repeat (20) cyc();
    check("en_low_hold", value, 16'h0777);

    // Scan with leading-zero blanking on 0042.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    @(negedge clk);
    do_load(16'h0042);
    for (int i = 0; i < 16; i++) begin
      cyc();
      idx = ((edges - 1) / 2) % 4;
      check($sformatf("scan_an_%0d", i), an, exp_an(idx));
      check($sformatf("scan_seg_%0d", i), seg, exp_seg(idx));
    end

    // Asynchronous reset in slot 2 while showing 1234.
    do_load(16'h1234);
    begin
      int guard = 0;
      cyc();
      while ((((edges - 1) / 2) % 4) != 2 && guard < 20) begin
        cyc();
        guard++;
      end
      check("find_slot2", guard < 20, 1'b1);
    end
    check("slot2_an", an, 4'b1011);
    check("slot2_seg", seg, 7'b0100100);
    #2;
    rst = 1'b0;
    #1;
    check("async_value", value, 16'h0000);
    check("async_an", an, 4'b1110);
    check("async_seg", seg, 7'b1000000);
    check("async_wrap", wrap, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
